uart_tx_param: RTL and testbench

//  Parametrised UART transmitter between the TX FIFO and the GPIO TX pin.

---
 rtl/uart_tx_param.sv | 240 ++++++++++++++++++++++++
 tb/tb_uart_tx_param.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, 5..DATA_W data bits LSB first, optional parity/9th bit, 1 or 2 stop bits.
// Optional line-break generation is built in when the macro UART_TX_BREAK_EN is defined.
`timescale 1ns/1ps
module uart_tx_param #(
  parameter int DATA_W  = 8,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_enable,
  input  logic               tx_request,
  output logic               tx_ack,
  input  logic [DATA_W:0]    DATA,
  input  logic [3:0]         data_bits,
  input  logic [1:0]         parity,
  input  logic               stop2,
  input  logic               send_break,
  output logic               TX_OUT,
  output logic               busy,
  output logic [STATE_W-1:0] stateOUT
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5,
    ST_BREAK  = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [3:0]          nbits_q, nbits_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                par_en_q, par_en_d;
  logic                par_bit_q, par_bit_d;
  logic                stop2_q, stop2_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                ack_q, ack_d;
  logic                sample_s;
  logic                brk_s;

  function automatic logic [3:0] clamp_bits(input logic [3:0] req);
    if (req < 4'd5) begin
      return 4'd5;
    end else if (req > 4'(DATA_W)) begin
      return 4'(DATA_W);
    end else begin
      return req;
    end
  endfunction

  // Parity/9th-bit value for a word of n data bits under the given mode.
  function automatic logic calc_parity(input logic [DATA_W:0] w, input logic [3:0] n,
                                       input logic [1:0] mode);
    logic p;
    p = 1'b0;
    for (int k = 0; k < DATA_W; k++) begin
      if (k < int'(n)) begin
        p = p ^ w[k];
      end else begin
        p = p;
      end
    end
    case (mode)
      2'b01:   return w[DATA_W];
      2'b10:   return p;
      2'b11:   return ~p;
      default: return 1'b1;
    endcase
  endfunction

`ifdef UART_TX_BREAK_EN
  assign brk_s = send_break;
`else
  logic unused_break_s;
  assign unused_break_s = send_break;
  assign brk_s          = 1'b0;
`endif

  // Next-state and output computation; ack defaults low so it is a single-clk pulse.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    nbits_d   = nbits_q;
    cnt_d     = cnt_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    ack_d     = 1'b0;
    sample_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d     = 1'b1;
        busy_d   = 1'b0;
        sample_s = clk_enable;
      end
      ST_START: begin
        if (clk_enable) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = 4'd0;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (clk_enable) begin
          if (cnt_q == (nbits_q - 4'd1)) begin
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = ST_STOP1;
              tx_d    = 1'b1;
            end
          end else begin
            cnt_d   = cnt_q + 4'd1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (clk_enable) begin
          state_d = ST_STOP1;
          tx_d    = 1'b1;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP1: begin
        if (clk_enable) begin
          if (stop2_q) begin
            state_d = ST_STOP2;
            tx_d    = 1'b1;
          end else begin
            sample_s = 1'b1;
          end
        end else begin
          state_d = ST_STOP1;
        end
      end
      ST_STOP2: begin
        sample_s = clk_enable;
      end
`ifdef UART_TX_BREAK_EN
      ST_BREAK: begin
        if (clk_enable) begin
          if (send_break) begin
            tx_d = 1'b0;
          end else begin
            state_d = ST_STOP1;
            tx_d    = 1'b1;
          end
        end else begin
          state_d = ST_BREAK;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = 4'd0;
      end
    endcase

    // Decision point shared by IDLE and the final stop tick: break, next word, or idle.
    if (sample_s) begin
      if (brk_s) begin
        state_d = ST_BREAK;
        tx_d    = 1'b0;
        busy_d  = 1'b1;
        stop2_d = 1'b0;
        cnt_d   = 4'd0;
      end else if (tx_request) begin
        state_d   = ST_START;
        tx_d      = 1'b0;
        busy_d    = 1'b1;
        ack_d     = 1'b1;
        cnt_d     = 4'd0;
        shift_d   = DATA[DATA_W-1:0];
        nbits_d   = clamp_bits(data_bits);
        par_en_d  = (parity != 2'b00);
        par_bit_d = calc_parity(DATA, clamp_bits(data_bits), parity);
        stop2_d   = stop2;
      end else begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = 4'd0;
      end
    end else begin
      sample_s = 1'b0;
    end
  end

  // State and output registers; reset leaves the line at mark immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      nbits_q   <= 4'd5;
      cnt_q     <= 4'd0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      nbits_q   <= nbits_d;
      cnt_q     <= cnt_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
    end
  end

  assign TX_OUT   = tx_q;
  assign busy     = busy_q;
  assign tx_ack   = ack_q;
  assign stateOUT = STATE_W'(state_q);

endmodule

// File: tb/tb_uart_tx_param.sv
// Randomised self-checking bench for uart_tx_param; expected line bits come from a frame-level model.
`timescale 1ns/1ps
module tb_uart_tx_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clk_enable = 1'b0;
  logic       tx_request = 1'b0;
  logic       tx_ack;
  logic [8:0] DATA = 9'h000;
  logic [3:0] data_bits = 4'd8;
  logic [1:0] parity = 2'b00;
  logic       stop2 = 1'b0;
  logic       send_break = 1'b0;
  logic       TX_OUT;
  logic       busy;
  logic [3:0] stateOUT;

  int errors = 0;
  int checks = 0;
  bit exp_q[$];

  uart_tx_param #(.DATA_W(8), .STATE_W(4)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .tx_request(tx_request),
    .tx_ack(tx_ack), .DATA(DATA), .data_bits(data_bits), .parity(parity),
    .stop2(stop2), .send_break(send_break), .TX_OUT(TX_OUT), .busy(busy),
    .stateOUT(stateOUT)
  );

  always #5 clk = ~clk;

  // Baud tick: one clk wide, every 4 clk.
  initial begin
    forever begin
      repeat (3) @(negedge clk);
      clk_enable = 1'b1;
      @(negedge clk);
      clk_enable = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!clk_enable && n < 16);
    #1;
    if (n >= 16) check("tick_wait", n, 4);
  endtask

  // Frame model: start, N data bits LSB first, optional parity/9th bit, stop bit(s).
  task automatic add_frame(input logic [8:0] w, input int db, input logic [1:0] par, input bit s2);
    int n;
    bit p;
    n = (db < 5) ? 5 : ((db > 8) ? 8 : db);
    p = 1'b0;
    exp_q.push_back(1'b0);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(w[k]);
      p ^= w[k];
    end
    if (par == 2'b01) exp_q.push_back(w[8]);
    else if (par == 2'b10) exp_q.push_back(p);
    else if (par == 2'b11) exp_q.push_back(~p);
    exp_q.push_back(1'b1);
    if (s2) exp_q.push_back(1'b1);
  endtask

  task automatic run_frame(input logic [8:0] w, input int db, input logic [1:0] par, input bit s2);
    int acks;
    acks = 0;
    exp_q.delete();
    add_frame(w, db, par, s2);
    @(negedge clk);
    DATA = w; data_bits = 4'(db); parity = par; stop2 = s2; tx_request = 1'b1;
    wait_tick();
    check("ack_pulse", tx_ack, 1);
    check("busy_start", busy, 1);
    check("start_bit", TX_OUT, exp_q[0]);
    check("state_start", stateOUT, 1);
    @(negedge clk);
    tx_request = 1'b0;
    DATA = 9'($urandom); data_bits = 4'($urandom); parity = 2'($urandom); stop2 = 1'($urandom);
    @(posedge clk); #1;
    check("ack_width", tx_ack, 0);
    for (int i = 1; i < exp_q.size(); i++) begin
      wait_tick();
      check("line_bit", TX_OUT, exp_q[i]);
      check("busy_frame", busy, 1);
      acks += int'(tx_ack);
    end
    wait_tick();
    check("idle_line", TX_OUT, 1);
    check("idle_busy", busy, 0);
    check("idle_state", stateOUT, 0);
    check("ack_count", acks, 0);
  endtask

  initial begin
    int ack_tick;
    int acks;
    repeat (3) @(negedge clk);
    check("rst_line", TX_OUT, 1);
    check("rst_ack", tx_ack, 0);
    check("rst_busy", busy, 0);
    check("rst_state", stateOUT, 0);
    reset = 1'b1;

    run_frame(9'h055, 8, 2'b00, 1'b0);
    run_frame(9'h041, 7, 2'b10, 1'b0);
    run_frame(9'h041, 7, 2'b11, 1'b0);
    run_frame(9'h1A5, 8, 2'b01, 1'b1);
    run_frame(9'h0FF, 2, 2'b10, 1'b0);
    run_frame(9'h1C3, 15, 2'b11, 1'b1);
    for (int r = 0; r < 30; r++) begin
      run_frame(9'($urandom), int'($urandom_range(0, 15)), 2'($urandom), 1'($urandom));
    end

    // Back-to-back frames with request held high.
    exp_q.delete();
    add_frame(9'h0FF, 8, 2'b00, 1'b0);
    add_frame(9'h000, 8, 2'b00, 1'b0);
    @(negedge clk);
    DATA = 9'h0FF; data_bits = 4'd8; parity = 2'b00; stop2 = 1'b0; tx_request = 1'b1;
    wait_tick();
    check("b2b_ack0", tx_ack, 1);
    check("b2b_bit0", TX_OUT, exp_q[0]);
    @(negedge clk);
    DATA = 9'h000;
    ack_tick = -1;
    acks = 0;
    for (int i = 1; i < 20; i++) begin
      wait_tick();
      check("b2b_bit", TX_OUT, exp_q[i]);
      check("b2b_busy", busy, 1);
      if (tx_ack) begin
        acks++;
        ack_tick = i;
        @(negedge clk);
        tx_request = 1'b0;
      end
    end
    check("b2b_acks", acks, 1);
    check("b2b_spacing", ack_tick, 10);
    wait_tick();
    check("b2b_idle", TX_OUT, 1);
    check("b2b_idle_busy", busy, 0);

    // Reset in the middle of data bit 3.
    @(negedge clk);
    DATA = 9'h000; data_bits = 4'd8; parity = 2'b00; stop2 = 1'b0; tx_request = 1'b1;
    wait_tick();
    @(negedge clk);
    tx_request = 1'b0;
    repeat (4) wait_tick();
    check("pre_rst_bit3", TX_OUT, 0);
    #3 reset = 1'b0;
    #1;
    check("mid_rst_line", TX_OUT, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_state", stateOUT, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      wait_tick();
      check("post_rst_line", TX_OUT, 1);
      check("post_rst_ack", tx_ack, 0);
    end

`ifdef UART_TX_BREAK_EN
    @(negedge clk);
    send_break = 1'b1;
    acks = 0;
    for (int i = 0; i < 25; i++) begin
      wait_tick();
      check("brk_line", TX_OUT, 0);
      check("brk_state", stateOUT, 6);
      acks += int'(tx_ack);
    end
    @(negedge clk);
    send_break = 1'b0;
    wait_tick();
    check("brk_mark", TX_OUT, 1);
    check("brk_stop_state", stateOUT, 4);
    wait_tick();
    check("brk_end_line", TX_OUT, 1);
    check("brk_end_state", stateOUT, 0);
    check("brk_end_busy", busy, 0);
    check("brk_acks", acks, 0);
`else
    @(negedge clk);
    send_break = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_tick();
      check("nobrk_line", TX_OUT, 1);
      check("nobrk_state", stateOUT, 0);
      check("nobrk_ack", tx_ack, 0);
    end
    @(negedge clk);
    send_break = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
